alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Controller that owns the 8-bit accumulator, the carry/zero/parity flag registers, and the command inputs of the single combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU with the correct command, operands and carry-in.
- Writes the ALU result back into the accumulator and updates the flags.
- Also performs an 8x8 multiply (low byte of the product) as a multi-cycle shift-and-add loop built from the ALU add and shift commands.

Parameters:
- MUL_STEPS, 8: number of multiplier bits iterated by MUL (1..8).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_kind  input  2  00 ALU op, 01 load immediate, 10 multiply, 11 clear.
- req_cmd  input  4  ALU command for kind 00.
- req_opr  input  8  operand, immediate, or multiplier.
- req_use_c  input  1  kind 00 only: 1 means cin = carry_flag, 0 means cin = 0.
- alu_cmd  output  4  to ALU alu_cmd.
- alu_acc  output  8  to ALU inAcc.
- alu_opr  output  8  to ALU inOpr.
- alu_cin  output  1  to ALU cin.
- alu_ld_immed  output  1  to ALU ldImmed.
- alu_result  input  8  from ALU result.
- alu_cout  input  1  from ALU cout.
- acc  output  8  accumulator register.
- carry_flag, zero_flag, pari_flag  output  1 each  flag registers.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: the operation's writeback is visible this cycle.

Behaviour:
- Reset: state=IDLE; acc=0; all flags=0; done=0. Internal prod/mcand/mult/count registers=0. A reset mid-operation abandons the operation with no writeback.
- Handshake:
  - A request is accepted in the cycle where req_valid && req_ready (call it cycle 0).
  - req_kind/req_cmd/req_opr/req_use_c are latched at that edge; inputs are don't-care afterwards.
  - No request is accepted while busy. Maximum throughput is one single-cycle op per 2 cycles.
- ALU drive in IDLE: alu_cmd=4'b1111, alu_opr=0, alu_cin=0, alu_ld_immed=0, alu_acc=acc.
- Flags:
  - zero_flag = (written value == 0) and pari_flag = ^(written value). Both are computed inside the sequencer.
  - The ALU's own zero/pari outputs are not used.
- States: IDLE, EXEC, MUL_ADD, MUL_SHF, MUL_WB.
- IDLE -> EXEC on acceptance of kind 00, 01 or 11. IDLE -> MUL_ADD on acceptance of kind 10.
- EXEC (cycle 1): ALU driven from the latched request with alu_acc=acc. Next state is always IDLE; done=1 in cycle 2.
  - kind 00: alu_cmd=req_cmd, alu_opr=req_opr, alu_cin per req_use_c.
    - acc<=alu_result except cmd 1111, which leaves acc and all flags unchanged.
    - carry_flag<=alu_cout for cmd 0000/1100/1101; otherwise carry_flag is held.
  - kind 01: alu_ld_immed=1, alu_opr=req_opr. acc<=alu_result (equals req_opr); carry_flag is held.
  - kind 11: ALU idle drive. acc<=0, carry_flag<=0, zero_flag<=1, pari_flag<=0.
- MUL, entry: prod<=0, mcand<=acc, mult<=req_opr, count<=0.
- MUL_ADD: alu_cmd=1100, alu_acc=prod, alu_opr=mcand, alu_cin=0. If mult[0], prod<=alu_result. Next state is MUL_SHF.
- MUL_SHF:
  - alu_cmd=0000, alu_acc=mcand, alu_opr=8'h00 (shift left by 1).
  - mcand<=alu_result; mult<=mult>>1; count<=count+1.
  - Next state is MUL_WB if count==MUL_STEPS-1, else MUL_ADD.
- MUL_WB: acc<=prod; carry_flag<=0; zero/pari from prod. Next state is IDLE; done=1 the following cycle.
- MUL latency: cycles 1..2*MUL_STEPS are ADD/SHF, cycle 2*MUL_STEPS+1 is WB, done in cycle 2*MUL_STEPS+2 (cycle 18 at default).
- Arithmetic: all values are 8-bit modulo 256. Product overflow is silently discarded; no flag reports it.
- busy is a register-derived output: high from cycle 1 through the writeback cycle.
- req_ready = !busy.

Optional Feature:
- Macro: ALU_SEQ_EARLY_EXIT_EN.
- Defined: in MUL_SHF, if the post-shift multiplier (mult>>1) == 0, go to MUL_WB immediately. Latency then depends on the position of the multiplier's top set bit. A multiplier of 0 exits after the first SHF (done in cycle 4).
- Undefined: fixed 2*MUL_STEPS iteration cycles regardless of operand.

Test Plan:
- Reset, then load immediate 8'h00 -> acc=0x00, zero_flag=1, pari_flag=0, done in cycle 2; then load 8'h07 -> acc=0x07, zero=0, pari=1.
- acc=0xF0; kind 00 cmd 1100 opr 0x20 use_c=0 -> acc=0x10, carry_flag=1. Then cmd 1100 opr 0x00 use_c=1 -> acc=0x11, carry_flag=0.
- acc=0x81; cmd 0000 opr 0x00 -> acc=0x02, carry_flag=1. Then cmd 1111 -> acc and all flags unchanged, done still pulses.
- acc=13; multiply opr=11 -> acc=143 (0x8F), carry=0, done exactly in cycle 18 (macro off). Then acc=16 multiply opr=16 -> acc=0x00, zero_flag=1.
- Macro on: acc=3, multiply opr=2 -> acc=6, done in cycle 6. Multiply opr=0 -> acc=0, done in cycle 4.
- Assert reset during MUL_SHF of a multiply -> next cycle acc=0, flags=0, busy=0, req_ready=1, no done pulse. req_valid held high during busy -> no second acceptance until IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequencer owning the accumulator and flags in front of a combinational ALU;
// also runs a shift-and-add multiply. Optional macro: ALU_SEQ_EARLY_EXIT_EN.
module alu_sequencer #(
   parameter int MUL_STEPS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_kind,
   input  logic [3:0] req_cmd,
   input  logic [7:0] req_opr,
   input  logic       req_use_c,
   output logic [3:0] alu_cmd,
   output logic [7:0] alu_acc,
   output logic [7:0] alu_opr,
   output logic       alu_cin,
   output logic       alu_ld_immed,
   input  logic [7:0] alu_result,
   input  logic       alu_cout,
   output logic [7:0] acc,
   output logic       carry_flag,
   output logic       zero_flag,
   output logic       pari_flag,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_EXEC    = 3'd1;
   localparam logic [2:0] S_MUL_ADD = 3'd2;
   localparam logic [2:0] S_MUL_SHF = 3'd3;
   localparam logic [2:0] S_MUL_WB  = 3'd4;

   localparam logic [1:0] K_ALU = 2'b00;
   localparam logic [1:0] K_LDI = 2'b01;
   localparam logic [1:0] K_MUL = 2'b10;
   localparam logic [1:0] K_CLR = 2'b11;

   localparam logic [3:0] LAST_COUNT = 4'(MUL_STEPS - 1);

   logic [2:0] state;
   logic [1:0] kind;
   logic [3:0] cmd;
   logic [7:0] opr;
   logic       use_c;
   logic [7:0] prod;
   logic [7:0] mcand;
   logic [7:0] mult;
   logic [3:0] count;
   logic       last_step;

   function automatic logic parity8(input logic [7:0] v);
      return ^v;
   endfunction

   function automatic logic is_zero8(input logic [7:0] v);
      return (v == 8'h00);
   endfunction

   function automatic logic writes_carry(input logic [3:0] c);
      return (c == 4'b0000) || (c == 4'b1100) || (c == 4'b1101);
   endfunction

   assign busy      = (state != S_IDLE);
   assign req_ready = !busy;

`ifdef ALU_SEQ_EARLY_EXIT_EN
   // Stop as soon as no multiplier bits remain after this shift.
   assign last_step = (count == LAST_COUNT) || (mult[7:1] == 7'd0);
`else
   assign last_step = (count == LAST_COUNT);
`endif

   always_comb begin
      alu_cmd      = 4'b1111;
      alu_acc      = acc;
      alu_opr      = 8'h00;
      alu_cin      = 1'b0;
      alu_ld_immed = 1'b0;
      case (state)
         S_EXEC: begin
            if (kind == K_ALU) begin
               alu_cmd = cmd;
               alu_opr = opr;
               alu_cin = use_c & carry_flag;
            end else if (kind == K_LDI) begin
               alu_ld_immed = 1'b1;
               alu_opr      = opr;
            end else begin
               alu_cmd = 4'b1111;
            end
         end
         S_MUL_ADD: begin
            alu_cmd = 4'b1100;
            alu_acc = prod;
            alu_opr = mcand;
         end
         S_MUL_SHF: begin
            alu_cmd = 4'b0000;
            alu_acc = mcand;
         end
         default: begin
            alu_cmd = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         kind       <= 2'b00;
         cmd        <= 4'b0000;
         opr        <= 8'h00;
         use_c      <= 1'b0;
         prod       <= 8'h00;
         mcand      <= 8'h00;
         mult       <= 8'h00;
         count      <= 4'd0;
         acc        <= 8'h00;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         pari_flag  <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  kind  <= req_kind;
                  cmd   <= req_cmd;
                  opr   <= req_opr;
                  use_c <= req_use_c;
                  if (req_kind == K_MUL) begin
                     prod  <= 8'h00;
                     mcand <= acc;
                     mult  <= req_opr;
                     count <= 4'd0;
                     state <= S_MUL_ADD;
                  end else begin
                     state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               state <= S_IDLE;
               done  <= 1'b1;
               case (kind)
                  K_ALU: begin
                     // Command 1111 is a no-op on the architectural state.
                     if (cmd != 4'b1111) begin
                        acc       <= alu_result;
                        zero_flag <= is_zero8(alu_result);
                        pari_flag <= parity8(alu_result);
                        if (writes_carry(cmd)) begin
                           carry_flag <= alu_cout;
                        end
                     end
                  end
                  K_LDI: begin
                     acc       <= alu_result;
                     zero_flag <= is_zero8(alu_result);
                     pari_flag <= parity8(alu_result);
                  end
                  K_CLR: begin
                     acc        <= 8'h00;
                     carry_flag <= 1'b0;
                     zero_flag  <= 1'b1;
                     pari_flag  <= 1'b0;
                  end
                  default: begin
                     acc <= acc;
                  end
               endcase
            end
            S_MUL_ADD: begin
               if (mult[0]) begin
                  prod <= alu_result;
               end
               state <= S_MUL_SHF;
            end
            S_MUL_SHF: begin
               mcand <= alu_result;
               mult  <= mult >> 1;
               count <= count + 4'd1;
               state <= last_step ? S_MUL_WB : S_MUL_ADD;
            end
            S_MUL_WB: begin
               acc        <= prod;
               carry_flag <= 1'b0;
               zero_flag  <= is_zero8(prod);
               pari_flag  <= parity8(prod);
               done       <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
